// File: rtl/arp_table_lookup.sv
// ARP resolution stage: linear scan of a register-programmed ARP table, one entry per cycle,
// with the result held stable until the downstream MAC-rewrite stage acknowledges it.
module arp_table_lookup #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned TABLE_DEPTH        = 32,
    parameter int unsigned TABLE_ADDR_BITS    = 5
) (
    input  logic                          AXI_ACLK,
    input  logic                          AXI_RESETN,
    input  logic                          lookup_req,
    input  logic [31:0]                   lookup_ip,
    input  logic [7:0]                    lookup_oq,
    output logic                          lookup_busy,
    output logic [47:0]                   dest_mac,
    output logic                          arp_hit,
    output logic [31:0]                   oq_reg,
    output logic                          result_valid,
    input  logic                          result_ack,
    input  logic                          tbl_wr_en,
    input  logic [TABLE_ADDR_BITS-1:0]    tbl_wr_addr,
    input  logic [31:0]                   tbl_wr_ip,
    input  logic [47:0]                   tbl_wr_mac,
    input  logic                          tbl_wr_valid,
    input  logic [TABLE_ADDR_BITS-1:0]    tbl_rd_addr,
    output logic [31:0]                   tbl_rd_ip,
    output logic [47:0]                   tbl_rd_mac,
    output logic                          tbl_rd_valid,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] reset,
    output logic [C_S_AXI_DATA_WIDTH-1:0] arp_lookup_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0] arp_hit_count
);

    typedef enum logic [1:0] {StIdle, StSearch, StDone} state_e;

    state_e                          state_q, state_d;
    logic [TABLE_ADDR_BITS-1:0]      idx_q;
    logic [31:0]                     ip_q;
    logic [7:0]                      oq_q;
    logic [7:0]                      oq_out_q;
    logic [47:0]                     mac_q;
    logic                            hit_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]   lookup_cnt_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]   hit_cnt_q;

    logic [31:0]                     tbl_ip_q    [TABLE_DEPTH];
    logic [47:0]                     tbl_mac_q   [TABLE_DEPTH];
    logic [TABLE_DEPTH-1:0]          tbl_valid_q;

    logic entry_match;
    logic last_idx;
    logic enter_done;

    // Address 0.0.0.0 is never a legal next hop, so it can never resolve.
    assign entry_match = tbl_valid_q[idx_q] && (tbl_ip_q[idx_q] == ip_q) && (ip_q != 32'd0);
    assign last_idx    = (idx_q == TABLE_ADDR_BITS'(TABLE_DEPTH - 1));
    assign enter_done  = (state_q == StSearch) && (entry_match || last_idx);

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (lookup_req) state_d = StSearch;
            StSearch: if (enter_done) state_d = StDone;
            StDone:   if (result_ack) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        lookup_busy  = (state_q != StIdle);
        result_valid = (state_q == StDone);
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            idx_q    <= '0;
            ip_q     <= '0;
            oq_q     <= '0;
            oq_out_q <= '0;
            mac_q    <= '0;
            hit_q    <= 1'b0;
        end else begin
            if (state_q == StIdle && lookup_req) begin
                ip_q  <= lookup_ip;
                oq_q  <= lookup_oq;
                idx_q <= '0;
            end
            if (state_q == StSearch) begin
                if (entry_match) begin
                    mac_q <= tbl_mac_q[idx_q];
                    hit_q <= 1'b1;
                end else if (last_idx) begin
                    mac_q <= '0;
                    hit_q <= 1'b0;
                end else begin
                    idx_q <= idx_q + TABLE_ADDR_BITS'(1);
                end
            end
            // Visible oq only changes when a new result lands, keeping it aligned with dest_mac.
            if (enter_done) begin
                oq_out_q <= oq_q;
            end
        end
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            lookup_cnt_q <= '0;
            hit_cnt_q    <= '0;
        end else if (reset == C_S_AXI_DATA_WIDTH'(1)) begin
            lookup_cnt_q <= '0;
            hit_cnt_q    <= '0;
        end else if (enter_done) begin
            if (~&lookup_cnt_q) lookup_cnt_q <= lookup_cnt_q + C_S_AXI_DATA_WIDTH'(1);
            if (entry_match && ~&hit_cnt_q) hit_cnt_q <= hit_cnt_q + C_S_AXI_DATA_WIDTH'(1);
        end
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            tbl_valid_q <= '0;
        end else if (tbl_wr_en) begin
            tbl_valid_q[tbl_wr_addr] <= tbl_wr_valid;
        end
    end

    // Entry payloads need no reset: they are qualified by the valid bits.
    always_ff @(posedge AXI_ACLK) begin
        if (tbl_wr_en) begin
            tbl_ip_q[tbl_wr_addr]  <= tbl_wr_ip;
            tbl_mac_q[tbl_wr_addr] <= tbl_wr_mac;
        end
    end

    assign dest_mac         = mac_q;
    assign arp_hit          = hit_q;
    assign oq_reg           = {24'b0, oq_out_q};
    assign arp_lookup_count = lookup_cnt_q;
    assign arp_hit_count    = hit_cnt_q;
    assign tbl_rd_ip        = tbl_ip_q[tbl_rd_addr];
    assign tbl_rd_mac       = tbl_mac_q[tbl_rd_addr];
    assign tbl_rd_valid     = tbl_valid_q[tbl_rd_addr];

endmodule

// File: tb/tb_arp_table_lookup.sv
// Directed bench for arp_table_lookup; counters are built 4 bits wide so that saturation at
// all-ones is reachable with a handful of lookups.
module tb_arp_table_lookup;

    localparam int unsigned CW    = 4;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          lookup_req;
    logic [31:0]   lookup_ip;
    logic [7:0]    lookup_oq;
    logic          lookup_busy;
    logic [47:0]   dest_mac;
    logic          arp_hit;
    logic [31:0]   oq_reg;
    logic          result_valid;
    logic          result_ack;
    logic          tbl_wr_en;
    logic [AW-1:0] tbl_wr_addr;
    logic [31:0]   tbl_wr_ip;
    logic [47:0]   tbl_wr_mac;
    logic          tbl_wr_valid;
    logic [AW-1:0] tbl_rd_addr;
    logic [31:0]   tbl_rd_ip;
    logic [47:0]   tbl_rd_mac;
    logic          tbl_rd_valid;
    logic [CW-1:0] cnt_reset;
    logic [CW-1:0] lookup_count;
    logic [CW-1:0] hit_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arp_table_lookup #(
        .C_S_AXI_DATA_WIDTH(CW),
        .TABLE_DEPTH       (DEPTH),
        .TABLE_ADDR_BITS   (AW)
    ) dut (
        .AXI_ACLK        (clk),
        .AXI_RESETN      (rst_n),
        .lookup_req      (lookup_req),
        .lookup_ip       (lookup_ip),
        .lookup_oq       (lookup_oq),
        .lookup_busy     (lookup_busy),
        .dest_mac        (dest_mac),
        .arp_hit         (arp_hit),
        .oq_reg          (oq_reg),
        .result_valid    (result_valid),
        .result_ack      (result_ack),
        .tbl_wr_en       (tbl_wr_en),
        .tbl_wr_addr     (tbl_wr_addr),
        .tbl_wr_ip       (tbl_wr_ip),
        .tbl_wr_mac      (tbl_wr_mac),
        .tbl_wr_valid    (tbl_wr_valid),
        .tbl_rd_addr     (tbl_rd_addr),
        .tbl_rd_ip       (tbl_rd_ip),
        .tbl_rd_mac      (tbl_rd_mac),
        .tbl_rd_valid    (tbl_rd_valid),
        .reset           (cnt_reset),
        .arp_lookup_count(lookup_count),
        .arp_hit_count   (hit_count)
    );

    typedef struct {
        logic [31:0] ip;
        logic [7:0]  oq;
        logic        hit;
        logic [47:0] mac;
        int          lat;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int idx, input logic [31:0] ip, input logic [47:0] mac, input logic v);
        tbl_wr_en    = 1'b1;
        tbl_wr_addr  = AW'(idx);
        tbl_wr_ip    = ip;
        tbl_wr_mac   = mac;
        tbl_wr_valid = v;
        tick();
        tbl_wr_en    = 1'b0;
    endtask

    // Returns the cycle (request cycle = 0) in which result_valid is first seen, -1 on timeout.
    task automatic lookup(input logic [31:0] ip, input logic [7:0] oq, output int lat);
        lookup_req = 1'b1;
        lookup_ip  = ip;
        lookup_oq  = oq;
        tick();
        lookup_req = 1'b0;
        lat = 1;
        while (!result_valid && lat < 100) begin
            tick();
            lat++;
        end
        if (!result_valid) lat = -1;
    endtask

    task automatic ack(input string name);
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        chk(name, {63'b0, result_valid}, 64'd0);
    endtask

    initial begin
        int          lat;
        logic        ok;
        logic [47:0] hold_mac;
        logic [31:0] hold_oq;

        vecs[0] = '{ip: 32'h0A00_0002, oq: 8'h04, hit: 1'b1, mac: 48'h0011_2233_4455, lat: 5};
        vecs[1] = '{ip: 32'hC0A8_0001, oq: 8'h01, hit: 1'b1, mac: 48'h0200_0000_0001, lat: 2};
        vecs[2] = '{ip: 32'hC0A8_0063, oq: 8'h80, hit: 1'b1, mac: 48'h0200_0000_00FF, lat: 33};
        vecs[3] = '{ip: 32'h0000_0000, oq: 8'h02, hit: 1'b0, mac: 48'h0, lat: 33};
        vecs[4] = '{ip: 32'h0A00_0005, oq: 8'h10, hit: 1'b0, mac: 48'h0, lat: 33};
        vecs[5] = '{ip: 32'h0A00_0009, oq: 8'h08, hit: 1'b0, mac: 48'h0, lat: 33};

        rst_n = 1'b0; lookup_req = 1'b0; lookup_ip = '0; lookup_oq = '0; result_ack = 1'b0;
        tbl_wr_en = 1'b0; tbl_wr_addr = '0; tbl_wr_ip = '0; tbl_wr_mac = '0; tbl_wr_valid = 1'b0;
        tbl_rd_addr = '0; cnt_reset = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        chk("rst_valid", {63'b0, result_valid}, 64'd0);
        chk("rst_busy", {63'b0, lookup_busy}, 64'd0);
        chk("rst_mac", {16'b0, dest_mac}, 64'd0);
        chk("rst_hit", {63'b0, arp_hit}, 64'd0);
        chk("rst_oq", {32'b0, oq_reg}, 64'd0);
        chk("rst_lcnt", {60'b0, lookup_count}, 64'd0);
        chk("rst_hcnt", {60'b0, hit_count}, 64'd0);

        // T2: empty table miss
        lookup(32'h0A00_0009, 8'h01, lat);
        chk("t2_lat", 64'(lat), 64'(DEPTH + 1));
        chk("t2_hit", {63'b0, arp_hit}, 64'd0);
        chk("t2_mac", {16'b0, dest_mac}, 64'd0);
        chk("t2_lcnt", {60'b0, lookup_count}, 64'd1);
        chk("t2_hcnt", {60'b0, hit_count}, 64'd0);
        ack("t2_ack");

        wr(3, 32'h0A00_0002, 48'h0011_2233_4455, 1'b1);
        wr(0, 32'hC0A8_0001, 48'h0200_0000_0001, 1'b1);
        wr(31, 32'hC0A8_0063, 48'h0200_0000_00FF, 1'b1);
        wr(10, 32'h0000_0000, 48'h1234_5678_9ABC, 1'b1);
        wr(12, 32'h0A00_0005, 48'h0A0A_0A0A_0A0A, 1'b1);
        wr(12, 32'h0A00_0005, 48'h0A0A_0A0A_0A0A, 1'b0);
        tbl_rd_addr = AW'(3);
        #1;
        chk("rd3_ip", {32'b0, tbl_rd_ip}, 64'h0A00_0002);
        chk("rd3_mac", {16'b0, tbl_rd_mac}, 64'h0011_2233_4455);
        chk("rd3_valid", {63'b0, tbl_rd_valid}, 64'd1);
        tbl_rd_addr = AW'(12);
        #1;
        chk("rd12_valid", {63'b0, tbl_rd_valid}, 64'd0);

        // T1 plus further hit/miss patterns
        for (int i = 0; i < 6; i++) begin
            lookup(vecs[i].ip, vecs[i].oq, lat);
            chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
            chk($sformatf("v%0d_hit", i), {63'b0, arp_hit}, {63'b0, vecs[i].hit});
            chk($sformatf("v%0d_mac", i), {16'b0, dest_mac}, {16'b0, vecs[i].mac});
            chk($sformatf("v%0d_oq", i), {32'b0, oq_reg}, {56'b0, vecs[i].oq});
            chk($sformatf("v%0d_busy", i), {63'b0, lookup_busy}, 64'd1);
            ack($sformatf("v%0d_ack", i));
        end
        chk("vec_lcnt", {60'b0, lookup_count}, 64'd7);
        chk("vec_hcnt", {60'b0, hit_count}, 64'd3);

        // T3: duplicate IP, lowest index wins
        wr(2, 32'h0A00_0007, 48'h0A0B_0C0D_0E0F, 1'b1);
        wr(7, 32'h0A00_0007, 48'hAABB_CCDD_EEFF, 1'b1);
        lookup(32'h0A00_0007, 8'h20, lat);
        chk("t3_lat", 64'(lat), 64'd4);
        chk("t3_mac", {16'b0, dest_mac}, 64'h0A0B_0C0D_0E0F);
        ack("t3_ack");

        // T4: result held while ack is withheld and req keeps pulsing
        lookup(32'hC0A8_0001, 8'h40, lat);
        chk("t4_lat", 64'(lat), 64'd2);
        hold_mac = dest_mac;
        hold_oq  = oq_reg;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            lookup_req = i[0];
            lookup_ip  = 32'h0A00_0002;
            lookup_oq  = 8'h02;
            tick();
            if (!result_valid || dest_mac !== hold_mac || oq_reg !== hold_oq || arp_hit !== 1'b1)
                ok = 1'b0;
        end
        chk("t4_stable", {63'b0, ok}, 64'd1);
        chk("t4_hold_mac", {16'b0, hold_mac}, 64'h0200_0000_0001);
        chk("t4_lcnt_hold", {60'b0, lookup_count}, 64'd9);
        lookup_req = 1'b1;
        result_ack = 1'b1;
        tick();
        lookup_req = 1'b0;
        result_ack = 1'b0;
        chk("t4_ack_idle", {62'b0, lookup_busy, result_valid}, 64'd0);
        lookup(32'h0A00_0002, 8'h02, lat);
        chk("t4_next_lat", 64'(lat), 64'd5);
        chk("t4_next_oq", {32'b0, oq_reg}, 64'h2);
        ack("t4_next_ack");
        chk("t4_lcnt", {60'b0, lookup_count}, 64'd10);

        // T6: saturation and clear priority
        cnt_reset = CW'(1);
        tick();
        cnt_reset = '0;
        chk("t6_clear", {56'b0, lookup_count, hit_count}, 64'd0);
        for (int i = 0; i < 15; i++) begin
            lookup(32'hC0A8_0001, 8'h01, lat);
            ack("t6_ack");
        end
        chk("t6_lcnt_full", {60'b0, lookup_count}, 64'hF);
        chk("t6_hcnt_full", {60'b0, hit_count}, 64'hF);
        lookup(32'hC0A8_0001, 8'h01, lat);
        chk("t6_lcnt_sat", {60'b0, lookup_count}, 64'hF);
        chk("t6_hcnt_sat", {60'b0, hit_count}, 64'hF);
        ack("t6_ack_sat");
        lookup_req = 1'b1;
        lookup_ip  = 32'hC0A8_0001;
        lookup_oq  = 8'h08;
        tick();
        lookup_req = 1'b0;
        cnt_reset  = CW'(1);
        tick();
        cnt_reset  = '0;
        chk("t6_prio_valid", {63'b0, result_valid}, 64'd1);
        chk("t6_prio_cnt", {56'b0, lookup_count, hit_count}, 64'd0);
        ack("t6_prio_ack");

        // T5: reset during SEARCH
        lookup_req = 1'b1;
        lookup_ip  = 32'h0A00_00FF;
        lookup_oq  = 8'h01;
        tick();
        lookup_req = 1'b0;
        repeat (5) tick();
        chk("t5_busy", {63'b0, lookup_busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_outs", {16'b0, dest_mac}, 64'd0);
        chk("t5_flags", {61'b0, lookup_busy, result_valid, arp_hit}, 64'd0);
        chk("t5_oq", {32'b0, oq_reg}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        ok = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            tbl_rd_addr = AW'(i);
            #1;
            if (tbl_rd_valid !== 1'b0) ok = 1'b0;
        end
        chk("t5_tbl_cleared", {63'b0, ok}, 64'd1);
        ok = 1'b1;
        repeat (40) begin
            tick();
            if (result_valid !== 1'b0 || lookup_busy !== 1'b0) ok = 1'b0;
        end
        chk("t5_no_result", {63'b0, ok}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
